// File: rtl/unified_mem_arbiter_if.sv
// Memory-side bus of the unified instruction/data memory arbiter.
// master = arbiter, slave = single-ported memory.
interface unified_mem_arbiter_if #(
    parameter int AW = 32
);
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_be_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_be_o,
        output mem_rdata_i,
        output mem_ack_i
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between fetch and the MEM stage.
// Data wins unless fetch has been starved for STARVE_LIMIT grants.
module unified_mem_arbiter #(
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    input  logic          if_flush_i,
    output logic          if_ack_o,
    output logic [31:0]   if_rdata_o,
    input  logic          d_rd_i,
    input  logic          d_wr_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [31:0]   d_wdata_i,
    input  logic [3:0]    d_be_i,
    output logic          d_ack_o,
    output logic [31:0]   d_rdata_o,
    output logic          busy_o,
    unified_mem_arbiter_if.master mem
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q;
    logic          flush_pend_q;
    logic          done_q;
    logic          d_req;
    logic          starved;
    logic          grant_d;
    logic          grant_i;
    logic          complete;

    assign d_req   = d_rd_i | d_wr_i;
    assign starved = starve_q >= CW'(STARVE_LIMIT);
    assign busy_o  = state_q != IDLE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // done_q marks the ack-pulse cycle, which is left free as a bubble
    always_comb begin
        state_d  = state_q;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!done_q) begin
                    if (d_req && (!starved || !if_req_i)) begin
                        grant_d = 1'b1;
                        state_d = D_BUSY;
                    end else if (if_req_i && !if_flush_i) begin
                        grant_i = 1'b1;
                        state_d = I_BUSY;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem.mem_ack_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q        <= '0;
            flush_pend_q    <= 1'b0;
            done_q          <= 1'b0;
            if_ack_o        <= 1'b0;
            if_rdata_o      <= '0;
            d_ack_o         <= 1'b0;
            d_rdata_o       <= '0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_wdata_o <= '0;
            mem.mem_be_o    <= '0;
        end else begin
            if_ack_o <= 1'b0;
            d_ack_o  <= 1'b0;
            done_q   <= complete;
            if (grant_d) begin
                mem.mem_req_o   <= 1'b1;
                mem.mem_we_o    <= d_wr_i;
                mem.mem_addr_o  <= d_addr_i;
                mem.mem_wdata_o <= d_wdata_i;
                mem.mem_be_o    <= d_wr_i ? d_be_i : 4'hF;
                if (!if_req_i)    starve_q <= '0;
                else if (!starved) starve_q <= starve_q + 1'b1;
            end
            if (grant_i) begin
                mem.mem_req_o   <= 1'b1;
                mem.mem_we_o    <= 1'b0;
                mem.mem_addr_o  <= if_addr_i;
                mem.mem_wdata_o <= '0;
                mem.mem_be_o    <= 4'hF;
                starve_q        <= '0;
            end
            if (state_q == I_BUSY && if_flush_i && !complete)
                flush_pend_q <= 1'b1;
            if (complete) begin
                mem.mem_req_o <= 1'b0;
                if (state_q == I_BUSY) begin
                    if_rdata_o   <= mem.mem_rdata_i;
                    if_ack_o     <= !(flush_pend_q || if_flush_i);
                    flush_pend_q <= 1'b0;
                end else begin
                    d_ack_o <= 1'b1;
                    if (!mem.mem_we_o) d_rdata_o <= mem.mem_rdata_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter.
// Memory responses are driven by hand from the stimulus thread.
module tb_unified_mem_arbiter;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, if_ack;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          d_rd, d_wr, d_ack;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic [3:0]    d_be;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    unified_mem_arbiter_if #(.AW(AW)) mem ();

    unified_mem_arbiter #(.AW(AW), .STARVE_LIMIT(4)) u_dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .if_req_i  (if_req),
        .if_addr_i (if_addr),
        .if_flush_i(if_flush),
        .if_ack_o  (if_ack),
        .if_rdata_o(if_rdata),
        .d_rd_i    (d_rd),
        .d_wr_i    (d_wr),
        .d_addr_i  (d_addr),
        .d_wdata_i (d_wdata),
        .d_be_i    (d_be),
        .d_ack_o   (d_ack),
        .d_rdata_o (d_rdata),
        .busy_o    (busy),
        .mem       (mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for mem_req_o, latches the request, acks it one cycle later.
    // Returns at the negedge where the owner's ack pulse is visible.
    task automatic serve(input logic [31:0] rdata, output logic [31:0] addr,
                         output logic we, output logic [3:0] be,
                         output logic [31:0] wdata);
        int n = 0;
        while (!mem.mem_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mem.mem_req_o) check("req_timeout", 32'(mem.mem_req_o), 1);
        addr  = mem.mem_addr_o;
        we    = mem.mem_we_o;
        be    = mem.mem_be_o;
        wdata = mem.mem_wdata_o;
        @(negedge clk);
        mem.mem_ack_i   = 1'b1;
        mem.mem_rdata_i = rdata;
        @(negedge clk);
        mem.mem_ack_i   = 1'b0;
        mem.mem_rdata_i = '0;
    endtask

    logic [31:0] a, wd;
    logic        we;
    logic [3:0]  be;
    logic [31:0] order [6];

    initial begin
        rst = 1'b1;
        if_req = 0; if_flush = 0; if_addr = '0;
        d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem.mem_ack_i = 1'b0;
        mem.mem_rdata_i = '0;
        order = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};
        #3;
        check("rst_req", 32'(mem.mem_req_o), 0);
        check("rst_be", 32'(mem.mem_be_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdata", if_rdata | d_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // fetch only
        if_req = 1; if_addr = 32'h40;
        serve(32'h00500093, a, we, be, wd);
        check("f_addr", a, 32'h40);
        check("f_we", 32'(we), 0);
        check("f_be", 32'(be), 32'hF);
        check("f_ack", 32'(if_ack), 1);
        check("f_rdata", if_rdata, 32'h00500093);
        if_req = 0;
        @(negedge clk);
        check("f_ack_pulse", 32'(if_ack), 0);
        check("f_busy", 32'(busy), 0);
        @(negedge clk);

        // store beats fetch, fetch follows after the bubble
        if_req = 1; if_addr = 32'h44;
        d_wr = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        serve(32'h0, a, we, be, wd);
        check("s_addr", a, 32'h100);
        check("s_we", 32'(we), 1);
        check("s_be", 32'(be), 32'h3);
        check("s_wdata", wd, 32'hDEADBEEF);
        check("s_dack", 32'(d_ack), 1);
        check("s_iack", 32'(if_ack), 0);
        d_wr = 0;
        @(negedge clk);
        check("s_bubble", 32'(mem.mem_req_o), 0);
        @(negedge clk);
        check("s_fgrant", 32'(mem.mem_req_o), 1);
        check("s_faddr", mem.mem_addr_o, 32'h44);
        serve(32'h11111111, a, we, be, wd);
        check("s_fack", 32'(if_ack), 1);
        if_req = 0;
        @(negedge clk);
        @(negedge clk);

        // starvation: D,D,D,D,I,D
        if_req = 1; if_addr = 32'h300;
        d_rd = 1; d_addr = 32'h400;
        for (int g = 0; g < 6; g++) begin
            serve(32'h1000 + g, a, we, be, wd);
            check($sformatf("starve_g%0d", g), a, order[g]);
            if (a == 32'h300) begin
                check("starve_iack", 32'(if_ack), 1);
                if_req = 0;
            end else begin
                check($sformatf("starve_dack%0d", g), 32'(d_ack), 1);
            end
        end
        d_rd = 0;
        @(negedge clk);
        @(negedge clk);

        // flush during I_BUSY
        if_req = 1; if_addr = 32'h80;
        serve_wait_flush();
        @(negedge clk);
        check("fl_bubble", 32'(mem.mem_req_o), 0);
        check("fl_ack2", 32'(if_ack), 0);
        serve(32'hABCD0123, a, we, be, wd);
        check("fl_addr2", a, 32'h200);
        check("fl_next_ack", 32'(if_ack), 1);
        check("fl_next_rdata", if_rdata, 32'hABCD0123);
        if_req = 0;
        @(negedge clk);
        @(negedge clk);

        // flush while IDLE blocks that cycle's fetch grant
        if_req = 1; if_addr = 32'h700; if_flush = 1;
        @(negedge clk);
        check("idle_flush", 32'(mem.mem_req_o), 0);
        if_flush = 0;
        @(negedge clk);
        check("idle_flush_grant", 32'(mem.mem_req_o), 1);
        serve(32'h77, a, we, be, wd);
        check("idle_flush_ack", 32'(if_ack), 1);
        if_req = 0;
        @(negedge clk);
        @(negedge clk);

        // async reset mid data access
        d_rd = 1; d_addr = 32'h500;
        @(negedge clk);
        check("rm_req", 32'(mem.mem_req_o), 1);
        #2 rst = 1'b1;
        #1;
        check("rm_req0", 32'(mem.mem_req_o), 0);
        check("rm_busy0", 32'(busy), 0);
        check("rm_dack0", 32'(d_ack), 0);
        @(negedge clk);
        d_rd = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem.mem_ack_i = 1'b1;
        mem.mem_rdata_i = 32'hBAD0BAD0;
        @(negedge clk);
        mem.mem_ack_i = 1'b0;
        check("rm_late_dack", 32'(d_ack), 0);
        check("rm_late_busy", 32'(busy), 0);
        @(negedge clk);
        check("rm_late_dack2", 32'(d_ack), 0);
        check("rm_late_rdata", d_rdata, 0);

        // load then store: store leaves d_rdata alone
        d_rd = 1; d_addr = 32'h600;
        serve(32'h12345678, a, we, be, wd);
        check("ld_be", 32'(be), 32'hF);
        check("ld_ack", 32'(d_ack), 1);
        check("ld_rdata", d_rdata, 32'h12345678);
        d_rd = 0;
        @(negedge clk);
        d_wr = 1; d_addr = 32'h604; d_wdata = 32'hCAFEF00D; d_be = 4'hF;
        serve(32'hFFFFFFFF, a, we, be, wd);
        check("st_we", 32'(we), 1);
        check("st_ack", 32'(d_ack), 1);
        check("st_rdata", d_rdata, 32'h12345678);
        d_wr = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // fetch 0x80 gets flushed one cycle in and redirected to 0x200
    task automatic serve_wait_flush();
        int n = 0;
        while (!mem.mem_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fl_req", 32'(mem.mem_req_o), 1);
        check("fl_addr", mem.mem_addr_o, 32'h80);
        if_flush = 1;
        if_addr  = 32'h200;
        @(negedge clk);
        if_flush = 0;
        check("fl_hold_addr", mem.mem_addr_o, 32'h80);
        mem.mem_ack_i   = 1'b1;
        mem.mem_rdata_i = 32'h55555555;
        @(negedge clk);
        mem.mem_ack_i   = 1'b0;
        mem.mem_rdata_i = '0;
        check("fl_no_ack", 32'(if_ack), 0);
        check("fl_busy", 32'(busy), 0);
    endtask
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the pipeline's fetch stage and MEM stage.
- MEM-stage loads/stores (driven by the control unit's mem_rd/mem_wr) have priority over fetch.
- A starvation counter guarantees fetch forward progress.
- Per-requester ack handshakes let the hazard logic stall IF or MEM until their access completes.

Parameters:
AW, 32, address width of both requesters and the memory port.
STARVE_LIMIT, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
if_req_i  input  1  fetch request; held with if_addr_i stable until if_ack_o or if_flush_i
if_addr_i  input  AW  fetch address (PC)
if_flush_i  input  1  fetch abort (branch/jump redirect); suppresses the ack of the in-flight fetch
if_ack_o  output  1  one-cycle pulse; if_rdata_o valid in the same cycle
if_rdata_o  output  32  fetched instruction, registered
d_rd_i  input  1  load request (from MEM stage mem_rd)
d_wr_i  input  1  store request (from MEM stage mem_wr)
d_addr_i  input  AW  data address (ALU result)
d_wdata_i  input  32  store data
d_be_i  input  4  store byte enables
d_ack_o  output  1  one-cycle pulse; d_rdata_o valid in the same cycle for loads
d_rdata_o  output  32  load data, registered
mem_req_o  output  1  memory request, held until mem_ack_i
mem_we_o  output  1  1 = write
mem_addr_o  output  AW  memory address
mem_wdata_o  output  32  memory write data
mem_be_o  output  4  byte enables; 4'b1111 for reads
mem_rdata_i  input  32  memory read data, valid with mem_ack_i
mem_ack_i  input  1  memory completion, one cycle, at least 1 cycle after mem_req_o rises
busy_o  output  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, starve_cnt=0, all outputs 0 (including rdata registers and mem_be_o), flush_pend=0.
- States are IDLE, I_BUSY and D_BUSY. All mem_* outputs are registered and load on the transition out of IDLE. They stay constant for the whole BUSY state.

Arbitration in IDLE:
- d_rd_i|d_wr_i and (starve_cnt<STARVE_LIMIT or !if_req_i) -> D_BUSY. If !if_req_i, starve_cnt is cleared; otherwise it is incremented.
- Else if if_req_i and !if_flush_i -> I_BUSY, starve_cnt=0.
- d_rd_i and d_wr_i both high is treated as a write.

Completion:
- In the BUSY states, when mem_ack_i=1: capture mem_rdata_i into the owner's rdata register and pulse the owner's ack in the next cycle. Return to IDLE, deassert mem_req_o.
- Minimum request-to-ack latency seen by a requester is 3 cycles: grant, ack, ack pulse.
- Acks for stores also pulse d_ack_o. d_rdata_o holds its previous value on stores.
- The IDLE cycle that coincides with an ack pulse is not used to grant, so the requester can drop or change its request. One bubble per access.

Flush:
- if_flush_i in IDLE: no effect other than suppressing a fetch grant that cycle.
- if_flush_i in I_BUSY sets flush_pend. The memory access still completes (no mid-transfer abort).
- The completing fetch's if_ack_o is suppressed, and flush_pend clears on that completion.
- A flush in the same cycle as mem_ack_i also suppresses that fetch's ack.

Other rules:
- Stall contract: requester stalls while req is high and ack has not pulsed. The arbiter generates no stall signal of its own.
- mem_ack_i while IDLE is ignored.
- Reset mid-access: asynchronous return to IDLE with mem_req_o=0 immediately, no acks issued. The memory must tolerate the abandoned request.
- Starve_cnt saturates at STARVE_LIMIT.

Test Plan:
- Fetch only, if_addr_i=0x40, mem acks 2 cycles after mem_req_o rises, mem_rdata_i=0x00500093 -> mem_addr_o=0x40, mem_we_o=0; if_ack_o one pulse with if_rdata_o=0x00500093; busy_o falls after ack.
- Simultaneous if_req_i (0x44) and d_wr_i (0x100, 0xDEADBEEF, be=4'b0011) -> store granted first: mem_we_o=1, mem_be_o=4'b0011. Fetch is granted on the next IDLE grant cycle after d_ack_o.
- Fetch held high with d_rd_i continuously high, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D... Fetch is served after exactly 4 data grants.
- if_flush_i pulsed 1 cycle into an I_BUSY fetch of 0x80 -> the memory access completes with no if_ack_o. Next fetch of 0x200 acks normally.
- rst_i asserted while D_BUSY, between two clock edges -> mem_req_o, busy_o and d_ack_o go 0 immediately. A late mem_ack_i after release is ignored.
- Load with mem_rdata_i=0x12345678 followed by a store -> d_rdata_o=0x12345678 after the load and is unchanged after the store's d_ack_o.
